// File: rtl/jace_video_pkg.sv
// Shared timing defaults, colour type and address-width helper for the Ace-style video generator.
package jace_video_pkg;

    localparam int H_TOTAL_DEF  = 416;
    localparam int V_TOTAL_DEF  = 312;
    localparam int COLS_DEF     = 32;
    localparam int ROWS_DEF     = 24;
    localparam int CHAR_H_DEF   = 8;
    localparam int HS_START_DEF = 310;
    localparam int HS_END_DEF   = 342;
    localparam int VS_START_DEF = 248;
    localparam int VS_END_DEF   = 255;
    localparam int HB_START_DEF = 296;
    localparam int HB_END_DEF   = 376;
    localparam int VB_START_DEF = 240;
    localparam int VB_END_DEF   = 264;
    localparam int SCR_AW_DEF   = 10;

    // Colour bits ordered {g, r, b}
    typedef logic [2:0] colour_t;

    // char_addr is {code[6:0], scanline-in-row}
    function automatic int char_aw(input int char_h);
        return 7 + $clog2(char_h);
    endfunction

endpackage

// File: rtl/jace_video_if.sv
// Video RAM port bundle: screen/char RAM addresses out, RAM data and cell attribute back in.
interface jace_video_if
    import jace_video_pkg::*;
#(
    parameter int SCR_AW  = SCR_AW_DEF,
    parameter int CHAR_AW = char_aw(CHAR_H_DEF)
);
    logic [SCR_AW-1:0]  screen_addr;
    logic [7:0]         screen_data;
    logic [CHAR_AW-1:0] char_addr;
    logic [7:0]         char_data;
    logic [5:0]         attr_data;

    modport master (
        output screen_addr,
        output char_addr,
        input  screen_data,
        input  char_data,
        input  attr_data
    );

    modport slave (
        input  screen_addr,
        input  char_addr,
        output screen_data,
        output char_data,
        output attr_data
    );
endinterface

// File: rtl/jace_video_timing.sv
// Line/frame counters, sync/blank decode, active flag and screen row-base accumulator.
// Optional JACE_VIDEO_FLASH_EN adds a 5-bit frame counter driving flash_o.
module jace_video_timing
    import jace_video_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int CHAR_H   = CHAR_H_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_END   = HS_END_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_END   = VS_END_DEF,
    parameter int HB_START = HB_START_DEF,
    parameter int HB_END   = HB_END_DEF,
    parameter int VB_START = VB_START_DEF,
    parameter int VB_END   = VB_END_DEF,
    parameter int SCR_AW   = SCR_AW_DEF,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int SLW     = (CHAR_H > 1) ? $clog2(CHAR_H) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [HW-1:0]     hcnt_o,
    output logic [SCR_AW-1:0] row_base_o,
    output logic [SLW-1:0]    fetch_sl_o,
    output logic              viden_o,
    output logic              hsync_n_o,
    output logic              vsync_n_o,
    output logic              blank_o,
    output logic              flash_o
);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0]     H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_WIN  = HW'(H_TOTAL - 3);
    localparam logic [HW-1:0]     H_RB   = HW'(H_TOTAL - 4);
    localparam logic [HW-1:0]     H_ACT  = HW'(COLS * 8);
    localparam logic [HW-1:0]     HS_S   = HW'(HS_START);
    localparam logic [HW-1:0]     HS_E   = HW'(HS_END);
    localparam logic [HW-1:0]     HB_S   = HW'(HB_START);
    localparam logic [HW-1:0]     HB_E   = HW'(HB_END);
    localparam logic [VW-1:0]     V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_ACT  = VW'(ROWS * CHAR_H);
    localparam logic [VW-1:0]     VS_S   = VW'(VS_START);
    localparam logic [VW-1:0]     VS_E   = VW'(VS_END);
    localparam logic [VW-1:0]     VB_S   = VW'(VB_START);
    localparam logic [VW-1:0]     VB_E   = VW'(VB_END);
    localparam logic [SLW-1:0]    SL_LAST = SLW'(CHAR_H - 1);
    localparam logic [SCR_AW-1:0] COLS_A  = SCR_AW'(COLS);

    logic [HW-1:0]     hcnt_q;
    logic [VW-1:0]     vcnt_q;
    logic [SCR_AW-1:0] row_base_q;
    logic              row_last;

    assign row_last = (CHAR_H == 1) || (vcnt_q[SLW-1:0] == SL_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            row_base_q <= '0;
        end else begin
            if (hcnt_q == H_LAST) begin
                hcnt_q <= '0;
                vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_q <= hcnt_q + 1'b1;
            end
            // Advance just before the cell-0 prefetch so it already sees the next row
            if (vcnt_q == V_LAST)
                row_base_q <= '0;
            else if (hcnt_q == H_RB && vcnt_q < V_ACT && row_last)
                row_base_q <= row_base_q + COLS_A;
        end
    end

    generate
        if (CHAR_H > 1) begin : g_sl
            logic [SLW-1:0] next_sl;
            assign next_sl    = (vcnt_q == V_LAST) ? '0 : vcnt_q[SLW-1:0] + 1'b1;
            assign fetch_sl_o = (hcnt_q >= H_WIN) ? next_sl : vcnt_q[SLW-1:0];
        end else begin : g_nosl
            assign fetch_sl_o = 1'b0;
        end
    endgenerate

`ifdef JACE_VIDEO_FLASH_EN
    logic [4:0] flash_q;
    always_ff @(posedge clk) begin
        if (!reset_n)
            flash_q <= '0;
        else if (hcnt_q == H_LAST && vcnt_q == V_LAST)
            flash_q <= flash_q + 1'b1;
    end
    assign flash_o = flash_q[4];
`else
    assign flash_o = 1'b0;
`endif

    assign hcnt_o     = hcnt_q;
    assign row_base_o = row_base_q;
    assign viden_o    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    assign hsync_n_o  = !(hcnt_q >= HS_S && hcnt_q <= HS_E);
    assign vsync_n_o  = !(vcnt_q >= VS_S && vcnt_q <= VS_E);
    assign blank_o    = (hcnt_q >= HB_S && hcnt_q < HB_E) || (vcnt_q >= VB_S && vcnt_q < VB_E);

endmodule

// File: rtl/jace_video_gen.sv
// Ace-style video generator: cell prefetch, pixel shifter, attribute colour, border and CPU contention.
// Define JACE_VIDEO_FLASH_EN to make inverse cells flash from a frame counter.
module jace_video_gen
    import jace_video_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int CHAR_H   = CHAR_H_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_END   = HS_END_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_END   = VS_END_DEF,
    parameter int HB_START = HB_START_DEF,
    parameter int HB_END   = HB_END_DEF,
    parameter int VB_START = VB_START_DEF,
    parameter int VB_END   = VB_END_DEF,
    parameter int SCR_AW   = SCR_AW_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_vram_req,
    jace_video_if.master       vram,
    input  logic [2:0]         border,
    output logic               wait_n,
    output logic               int_n,
    output logic               r,
    output logic               g,
    output logic               b,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               viden
);
    localparam int HW  = $clog2(H_TOTAL);
    localparam int SLW = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
    localparam logic [HW-1:0]     H_WIN  = HW'(H_TOTAL - 3);
    localparam logic [SCR_AW-1:0] COLS_A = SCR_AW'(COLS);

    logic [HW-1:0]     hcnt;
    logic [SCR_AW-1:0] row_base;
    logic [SLW-1:0]    fetch_sl;
    logic              viden_c, hsync_c, vsync_c, blank_c, flash;

    jace_video_timing #(
        .H_TOTAL (H_TOTAL),  .V_TOTAL (V_TOTAL),  .COLS    (COLS),
        .ROWS    (ROWS),     .CHAR_H  (CHAR_H),   .HS_START(HS_START),
        .HS_END  (HS_END),   .VS_START(VS_START), .VS_END  (VS_END),
        .HB_START(HB_START), .HB_END  (HB_END),   .VB_START(VB_START),
        .VB_END  (VB_END),   .SCR_AW  (SCR_AW)
    ) u_timing (
        .clk       (clk),
        .reset_n   (reset_n),
        .hcnt_o    (hcnt),
        .row_base_o(row_base),
        .fetch_sl_o(fetch_sl),
        .viden_o   (viden_c),
        .hsync_n_o (hsync_c),
        .vsync_n_o (vsync_c),
        .blank_o   (blank_c),
        .flash_o   (flash)
    );

    logic              in_win, fvalid;
    logic [2:0]        ph;
    logic [SCR_AW-1:0] fcol;
    logic [6:0]        code_sel;
    logic [7:0]        code_q, shift_q;
    logic              inv_q, wait_q, hsync_q, vsync_q, blank_q;
    colour_t           rgb_q, rgb_d, ink, paper;

    // Each cell is fetched during phases 5..7 of the cell before it; the end-of-line window fetches cell 0
    always_comb begin
        in_win = (hcnt >= H_WIN);
        if (in_win) begin
            ph   = 3'(hcnt - H_WIN) + 3'd5;
            fcol = '0;
        end else begin
            ph   = hcnt[2:0];
            fcol = SCR_AW'(hcnt[HW-1:3]) + 1'b1;
        end
        fvalid = (fcol < COLS_A);
    end

    assign vram.screen_addr = row_base + fcol;
    assign code_sel = (ph == 3'd6) ? vram.screen_data[6:0] : code_q[6:0];

    generate
        if (CHAR_H > 1) begin : g_caddr
            assign vram.char_addr = {code_sel, fetch_sl};
        end else begin : g_caddr_flat
            assign vram.char_addr = code_sel;
        end
    endgenerate

    assign ink   = vram.attr_data[5:3];
    assign paper = vram.attr_data[2:0];

    always_comb begin
        rgb_d = border;
        if (blank_c)
            rgb_d = '0;
        else if (viden_c)
            rgb_d = (shift_q[7] ^ (inv_q & ~flash)) ? ink : paper;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            code_q  <= '0;
            shift_q <= '0;
            inv_q   <= 1'b0;
            wait_q  <= 1'b1;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            if (ph == 3'd6)
                code_q <= vram.screen_data;
            if (ph == 3'd7) begin
                shift_q <= fvalid ? vram.char_data : 8'h00;
                inv_q   <= fvalid & code_q[7];
            end else begin
                shift_q <= {shift_q[6:0], 1'b0};
            end
            wait_q  <= !(cpu_vram_req && viden_c);
            hsync_q <= hsync_c;
            vsync_q <= vsync_c;
            blank_q <= blank_c;
            rgb_q   <= rgb_d;
        end
    end

    assign wait_n = wait_q;
    assign int_n  = vsync_q;
    assign vsync  = vsync_q;
    assign hsync  = hsync_q;
    assign blank  = blank_q;
    assign viden  = viden_c;
    assign g      = rgb_q[2];
    assign r      = rgb_q[1];
    assign b      = rgb_q[0];

endmodule

// File: tb/tb_jace_video_gen.sv
// Directed bench for jace_video_gen on a shortened 60-line frame with 40 columns of 2-line characters.
module tb_jace_video_gen;
    import jace_video_pkg::*;

    localparam int H_TOTAL = 416;
    localparam int V_TOTAL = 60;
    localparam int COLS    = 40;
    localparam int ROWS    = 24;
    localparam int CHAR_H  = 2;
    localparam int SCR_AW  = 10;
    localparam int CHAR_AW = char_aw(CHAR_H);
    localparam int LIMIT   = 30000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_vram_req = 1'b0;
    logic [2:0] border = 3'b101;
    logic       wait_n, int_n, r, g, b, hsync, vsync, blank, viden;

    jace_video_if #(.SCR_AW(SCR_AW), .CHAR_AW(CHAR_AW)) vram ();

    jace_video_gen #(
        .H_TOTAL (H_TOTAL), .V_TOTAL (V_TOTAL), .COLS    (COLS),
        .ROWS    (ROWS),    .CHAR_H  (CHAR_H),  .HS_START(344),
        .HS_END  (376),     .VS_START(54),      .VS_END  (56),
        .HB_START(336),     .HB_END  (400),     .VB_START(52),
        .VB_END  (58),      .SCR_AW  (SCR_AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_vram_req(cpu_vram_req),
        .vram        (vram),
        .border      (border),
        .wait_n      (wait_n),
        .int_n       (int_n),
        .r           (r),
        .g           (g),
        .b           (b),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .viden       (viden)
    );

    always #5 clk = ~clk;

    // Synchronous RAM models, one clock read latency
    logic [7:0] screen_mem [1024];
    logic [7:0] char_mem   [256];
    always_ff @(posedge clk) begin
        vram.screen_data <= screen_mem[vram.screen_addr];
        vram.char_data   <= char_mem[vram.char_addr];
    end
    assign vram.attr_data = 6'b111_000;

    // Bench position model: th/tv equal the expected hcnt/vcnt during the current cycle
    int th = 0;
    int tv = 0;
    always @(posedge clk) begin
        if (!reset_n) begin
            th <= 0;
            tv <= 0;
        end else if (th == H_TOTAL - 1) begin
            th <= 0;
            tv <= (tv == V_TOTAL - 1) ? 0 : tv + 1;
        end else begin
            th <= th + 1;
        end
    end

    // Frame interrupt monitor
    int   cyc = 0;
    int   nfall = 0;
    int   fall_t [2];
    int   low_run = 0;
    int   low_len = 0;
    logic int_prev = 1'b1;
    always @(negedge clk) begin
        int_prev <= int_n;
        if (!reset_n) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (int_prev && !int_n && nfall < 2) begin
                fall_t[nfall] <= cyc;
                nfall <= nfall + 1;
            end
            if (!int_n) begin
                low_run <= low_run + 1;
            end else begin
                if (low_run != 0 && low_len == 0)
                    low_len <= low_run;
                low_run <= 0;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (line %0d, pixel clock %0d)", tag, got, exp, tv, th);
        end else begin
            $display("check %s: %0h ok (line %0d, pixel clock %0d)", tag, got, tv, th);
        end
    endtask

    task automatic goto_pos(input int h, input int v);
        int n;
        n = 0;
        while (!(th == h && tv == v) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT)
            check("goto_timeout", 32'(n), 32'(0));
    endtask

    logic [2:0] px_exp [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b111,
                                3'b111, 3'b111, 3'b111, 3'b111, 3'b000};

    initial begin
        for (int i = 0; i < 1024; i++) screen_mem[i] = 8'h00;
        for (int i = 0; i < 256; i++)  char_mem[i]   = 8'h00;
        screen_mem[0]  = 8'h81;   // inverse, code 1
        screen_mem[1]  = 8'h05;
        screen_mem[41] = 8'h03;
        char_mem[2]    = 8'hF0;   // code 1, scanline 0
        char_mem[10]   = 8'hAA;   // code 5, scanline 0

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Stall in the active area, then reset while stalled
        goto_pos(20, 0);
        cpu_vram_req = 1'b1;
        goto_pos(22, 0);
        check("stall_before_reset", wait_n, 1'b0);
        goto_pos(100, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_wait_n", wait_n, 1'b1);
        check("reset_rgb", {g, r, b}, 3'b000);
        check("reset_int_n", int_n, 1'b1);
        check("reset_hsync", hsync, 1'b1);
        check("reset_blank", blank, 1'b0);
        check("reset_viden_at_origin", viden, 1'b1);
        cpu_vram_req = 1'b0;
        reset_n = 1'b1;

        // Address generation
        goto_pos(5, 0);
        check("scr_addr_cell1", vram.screen_addr, 32'd1);
        goto_pos(6, 0);
        check("char_addr_cell1", vram.char_addr, 32'h0A);
        goto_pos(413, 1);
        check("scr_addr_row1_cell0", vram.screen_addr, 32'd40);
        goto_pos(5, 3);
        check("scr_addr_row1_cell1", vram.screen_addr, 32'd41);
        goto_pos(6, 3);
        check("char_addr_scanline1", vram.char_addr, 32'h07);

        // Contention across a line edge
        goto_pos(10, 5);
        cpu_vram_req = 1'b1;
        check("wait_before_req", wait_n, 1'b1);
        goto_pos(11, 5);
        check("wait_falls", wait_n, 1'b0);
        goto_pos(320, 5);
        check("wait_last_active", wait_n, 1'b0);
        goto_pos(321, 5);
        check("wait_right_edge", wait_n, 1'b1);
        goto_pos(1, 6);
        check("wait_next_line", wait_n, 1'b0);
        goto_pos(50, 6);
        cpu_vram_req = 1'b0;
        goto_pos(51, 6);
        check("wait_req_drop", wait_n, 1'b1);

        goto_pos(321, 10);
        check("border_right_of_active", {g, r, b}, 3'b101);
        goto_pos(309, 47);
        check("scr_addr_last_cell", vram.screen_addr, 32'd959);

        // Below the active rows: border, no contention, blanking and sync
        goto_pos(10, 50);
        cpu_vram_req = 1'b1;
        goto_pos(12, 50);
        check("wait_outside_active", wait_n, 1'b1);
        cpu_vram_req = 1'b0;
        goto_pos(101, 50);
        check("border_rgb", {g, r, b}, 3'b101);
        check("border_blank", blank, 1'b0);
        goto_pos(340, 50);
        check("hblank", blank, 1'b1);
        check("hblank_rgb", {g, r, b}, 3'b000);
        goto_pos(344, 50);
        check("hsync_before", hsync, 1'b1);
        goto_pos(345, 50);
        check("hsync_start", hsync, 1'b0);
        goto_pos(377, 50);
        check("hsync_end", hsync, 1'b0);
        goto_pos(378, 50);
        check("hsync_after", hsync, 1'b1);
        goto_pos(101, 53);
        check("vblank", blank, 1'b1);
        check("vblank_rgb", {g, r, b}, 3'b000);
        goto_pos(0, 54);
        check("vsync_before", vsync, 1'b1);
        goto_pos(1, 54);
        check("vsync_start", vsync, 1'b0);
        goto_pos(0, 57);
        check("vsync_end", vsync, 1'b0);
        goto_pos(1, 57);
        check("vsync_after", vsync, 1'b1);

        // Second frame, line 0: inverse cell 0 then plain cell 1
        goto_pos(0, 0);
        for (int i = 0; i < 10; i++) begin
            goto_pos(i + 1, 0);
            check($sformatf("pixel%0d", i), {g, r, b}, px_exp[i]);
        end

        goto_pos(2, 57);
        check("int_fall_count", 32'(nfall), 32'd2);
        check("frame_period", 32'(fall_t[1] - fall_t[0]), 32'(H_TOTAL * V_TOTAL));
        check("int_low_clocks", 32'(low_len), 32'(3 * H_TOTAL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
